// File: rtl/fadd_issue_arbiter_if.sv
// Request channel for one fadd issue requester: operands, op select, tag and handshake.
interface fadd_issue_arbiter_if #(
    parameter int TAG_W = 5
);
    logic             valid;
    logic             ready;
    logic [31:0]      s;
    logic [31:0]      t;
    logic             sub;
    logic [TAG_W-1:0] tag;

    modport master (output valid, s, t, sub, tag, input ready);
    modport slave  (input valid, s, t, sub, tag, output ready);
endinterface

// File: rtl/fadd_issue_arbiter.sv
// Round-robin issue of two requesters onto one non-stalling pipelined fadd unit;
// id/tag travel in a shadow pipeline so each result returns with its owner.
module fadd_issue_arbiter #(
    parameter int TAG_W = 5,
    parameter int LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fadd_issue_arbiter_if.slave  req0,
    fadd_issue_arbiter_if.slave  req1,
    input  logic                 flush_i,
    output logic [31:0]          fadd_s_o,
    output logic [31:0]          fadd_t_o,
    input  logic [31:0]          fadd_d_i,
    output logic                 res_valid_o,
    output logic                 res_id_o,
    output logic [TAG_W-1:0]     res_tag_o,
    output logic [31:0]          res_d_o,
    output logic [2:0]           inflight_o,
    output logic                 idle_o
);
    logic                      ptr_q, ptr_d;
    logic                      gnt0, gnt1;
    logic                      acc, acc_id;
    logic [31:0]               fadd_s_q, fadd_s_d;
    logic [31:0]               fadd_t_q, fadd_t_d;
    logic [TAG_W-1:0]          iss_tag;
    logic [LAT:0]              vld_pipe_q, vld_pipe_d;
    logic [LAT:0]              id_pipe_q, id_pipe_d;
    logic [LAT:0][TAG_W-1:0]   tag_pipe_q, tag_pipe_d;
    logic [2:0]                inflight_q, inflight_d;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0.valid && req1.valid) begin
            gnt0 = ~ptr_q;
            gnt1 = ptr_q;
        end else begin
            gnt0 = req0.valid;
            gnt1 = req1.valid;
        end
    end

    assign req0.ready = gnt0 & ~flush_i & ~rst;
    assign req1.ready = gnt1 & ~flush_i & ~rst;
    assign acc        = req0.ready | req1.ready;
    assign acc_id     = req1.ready;

    always_comb begin
        ptr_d      = ptr_q;
        fadd_s_d   = fadd_s_q;
        fadd_t_d   = fadd_t_q;
        iss_tag    = '0;
        inflight_d = inflight_q;
        if (acc) begin
            ptr_d = ~ptr_q;
            if (acc_id) begin
                fadd_s_d = req1.s;
                fadd_t_d = {req1.t[31] ^ req1.sub, req1.t[30:0]};
                iss_tag  = req1.tag;
            end else begin
                fadd_s_d = req0.s;
                fadd_t_d = {req0.t[31] ^ req0.sub, req0.t[30:0]};
                iss_tag  = req0.tag;
            end
        end
        // Slot 0 is the issue register; slot LAT lines up with fadd_d_i.
        vld_pipe_d = flush_i ? '0 : {vld_pipe_q[LAT-1:0], acc};
        id_pipe_d  = {id_pipe_q[LAT-1:0], acc_id};
        tag_pipe_d = {tag_pipe_q[LAT-1:0], iss_tag};
        if (flush_i) begin
            inflight_d = 3'd0;
        end else if (acc && !vld_pipe_q[LAT]) begin
            inflight_d = inflight_q + 3'd1;
        end else if (!acc && vld_pipe_q[LAT]) begin
            inflight_d = inflight_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= 1'b0;
            fadd_s_q   <= '0;
            fadd_t_q   <= '0;
            vld_pipe_q <= '0;
            id_pipe_q  <= '0;
            tag_pipe_q <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            fadd_s_q   <= fadd_s_d;
            fadd_t_q   <= fadd_t_d;
            vld_pipe_q <= vld_pipe_d;
            id_pipe_q  <= id_pipe_d;
            tag_pipe_q <= tag_pipe_d;
            inflight_q <= inflight_d;
        end
    end

    assign fadd_s_o    = fadd_s_q;
    assign fadd_t_o    = fadd_t_q;
    assign res_valid_o = vld_pipe_q[LAT];
    assign res_id_o    = id_pipe_q[LAT];
    assign res_tag_o   = tag_pipe_q[LAT];
    assign res_d_o     = fadd_d_i;
    assign inflight_o  = inflight_q;
    assign idle_o      = (inflight_q == 3'd0);
endmodule

// File: tb/tb_fadd_issue_arbiter.sv
// Directed bench for fadd_issue_arbiter: scoreboard model checked every cycle plus literal checks.
module tb_fadd_issue_arbiter;
    localparam int TAG_W = 5;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [31:0]      fadd_s, fadd_t, fadd_d, res_d;
    logic             res_valid, res_id, idle;
    logic [TAG_W-1:0] res_tag;
    logic [2:0]       inflight;
    logic [31:0]      p1, p2;
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;

    fadd_issue_arbiter_if #(.TAG_W(TAG_W)) r0();
    fadd_issue_arbiter_if #(.TAG_W(TAG_W)) r1();

    fadd_issue_arbiter #(.TAG_W(TAG_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req0(r0.slave), .req1(r1.slave), .flush_i(flush),
        .fadd_s_o(fadd_s), .fadd_t_o(fadd_t), .fadd_d_i(fadd_d),
        .res_valid_o(res_valid), .res_id_o(res_id), .res_tag_o(res_tag),
        .res_d_o(res_d), .inflight_o(inflight), .idle_o(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in fadd: exact for the IEEE vectors used, deterministic scramble otherwise.
    function automatic logic [31:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
        if (a === 32'h3F800000 && b === 32'h40000000) return 32'h40400000;
        if (a === 32'h40400000 && b === 32'hBF800000) return 32'h40000000;
        if (a === 32'h3F800000 && b === 32'h3F800000) return 32'h40000000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    always @(posedge clk) begin
        p1 <= fadd_ref(fadd_s, fadd_t);
        p2 <= p1;
    end
    assign fadd_d = p2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int               due;
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      d;
    } ent_t;

    ent_t q[$];
    logic m_ptr = 1'b0;

    // Model: results due 1+LAT cycles after acceptance, in order; inflight = pending count.
    always @(negedge clk) begin
        logic g0, g1, a0, a1, due_now;
        ent_t e;
        g0 = r0.valid && (!r1.valid || !m_ptr);
        g1 = r1.valid && (!r0.valid || m_ptr);
        a0 = g0 && !flush && !rst;
        a1 = g1 && !flush && !rst;
        chk("ready0", r0.ready, a0);
        chk("ready1", r1.ready, a1);
        if (rst) begin
            q.delete();
            m_ptr = 1'b0;
        end else begin
            due_now = (q.size() > 0) && (q[0].due == cyc);
            chk("res_valid", res_valid, due_now);
            chk("inflight", inflight, q.size());
            chk("idle", idle, q.size() == 0);
            if (due_now) begin
                chk("res_id", res_id, q[0].id);
                chk("res_tag", res_tag, q[0].tag);
                chk("res_d", res_d, q[0].d);
                void'(q.pop_front());
            end
            if (flush) q.delete();
            else if (a0 || a1) begin
                e.due = cyc + 1 + LAT;
                e.id  = a1;
                e.tag = a1 ? r1.tag : r0.tag;
                e.d   = a1 ? fadd_ref(r1.s, {r1.t[31] ^ r1.sub, r1.t[30:0]})
                           : fadd_ref(r0.s, {r0.t[31] ^ r0.sub, r0.t[30:0]});
                q.push_back(e);
                m_ptr = ~m_ptr;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        r0.valid = 0; r0.s = 0; r0.t = 0; r0.sub = 0; r0.tag = 0;
        r1.valid = 0; r1.s = 0; r1.t = 0; r1.sub = 0; r1.tag = 0;
    endtask

    task automatic idle_n(input int n);
        clr();
        repeat (n) next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; flush = 0; clr();
        next(); next();
        rst = 0;
        @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_fadd_s", fadd_s, 0);
        chk("rst_fadd_t", fadd_t, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_idle", idle, 1);

        // T1: add through port 0
        next();
        r0.valid = 1; r0.s = 32'h3F800000; r0.t = 32'h40000000; r0.sub = 0; r0.tag = 5;
        @(negedge clk); chk("t1_ready0", r0.ready, 1);
        next(); clr();
        next(); next();
        @(negedge clk);
        chk("t1_valid", res_valid, 1);
        chk("t1_d", res_d, 32'h40400000);
        chk("t1_id", res_id, 0);
        chk("t1_tag", res_tag, 5);
        next();
        @(negedge clk); chk("t1_one_pulse", res_valid, 0);
        idle_n(3);

        // T2: subtract through port 1
        r1.valid = 1; r1.s = 32'h40400000; r1.t = 32'h3F800000; r1.sub = 1; r1.tag = 9;
        @(negedge clk); chk("t2_ready1", r1.ready, 1);
        next(); clr();
        @(negedge clk); chk("t2_fadd_t", fadd_t, 32'hBF800000);
        next(); next();
        @(negedge clk);
        chk("t2_d", res_d, 32'h40000000);
        chk("t2_id", res_id, 1);
        idle_n(4);

        // T3: both ports contend every cycle
        for (int i = 0; i < 6; i++) begin
            r0.valid = 1; r0.s = 32'h1000 + i; r0.t = 32'h0A0A0000 + i; r0.sub = i[0]; r0.tag = 10 + i;
            r1.valid = 1; r1.s = 32'h2000 + i; r1.t = 32'h05050000 + i; r1.sub = i[1]; r1.tag = 20 + i;
            @(negedge clk);
            if (i == 0) chk("t3_first_port0", r0.ready, 1);
            if (i == 1) chk("t3_second_port1", r1.ready, 1);
            next();
        end
        idle_n(5);

        // T4: port 0 streams alone
        for (int i = 0; i < 8; i++) begin
            r0.valid = 1; r0.s = 32'h3000 * (i + 1); r0.t = 32'h00770000 + i; r0.tag = 5'(i);
            @(negedge clk);
            chk("t4_ready0", r0.ready, 1);
            if (i == 5) chk("t4_inflight", inflight, 3);
            next();
        end
        idle_n(5);

        // T5: flush with tags 2 and 3 in flight
        for (int i = 1; i <= 3; i++) begin
            r0.valid = 1; r0.s = 32'h3F800000; r0.t = 32'h3F800000; r0.tag = 5'(i);
            next();
        end
        r0.tag = 4; flush = 1;
        @(negedge clk);
        chk("t5_no_accept", r0.ready, 0);
        chk("t5_tag1_valid", res_valid, 1);
        chk("t5_tag1_tag", res_tag, 1);
        next(); flush = 0; clr();
        @(negedge clk);
        chk("t5_inflight", inflight, 0);
        chk("t5_no_tag2", res_valid, 0);
        next();
        @(negedge clk); chk("t5_no_tag3", res_valid, 0);
        idle_n(3);

        // T6: reset mid-flight
        for (int i = 0; i < 3; i++) begin
            r0.valid = 1; r0.s = 32'h4444 + i; r0.t = 32'h1234; r0.tag = 5'(7 + i);
            next();
        end
        rst = 1;
        @(negedge clk); chk("t6_ready_in_rst", r0.ready, 0);
        next(); rst = 0;
        r0.valid = 1; r0.tag = 12; r1.valid = 1; r1.s = 32'h55; r1.t = 32'h66; r1.tag = 13;
        @(negedge clk);
        chk("t6_ptr0_r0", r0.ready, 1);
        chk("t6_ptr0_r1", r1.ready, 0);
        chk("t6_gone_a", res_valid, 0);
        next(); clr();
        @(negedge clk); chk("t6_gone_b", res_valid, 0);
        idle_n(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
